alu_multiply_sequencer: RTL

Multi-cycle unsigned 16×16→32 multiplier that uses the 32-bit ArithmeticLogicUnit for all of its additions and shifts. It sits directly upstream of the ALU: it drives the ALU's A, B, FunSel and WF inputs, and it takes back the ALU's registered ALUOut one cycle later. The block uses shift-and-add. It keeps the partial product and the shifted multiplicand locally, and the ALU performs every datapath operation on them.

---
 rtl/alu_multiply_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multiply_sequencer.sv
// ---------------------------------------------------------------------------
// alu_multiply_sequencer
//
// Multi-cycle unsigned 16x16->32 shift-and-add multiplier. The block has no
// adder or shifter of its own. It keeps the partial product (P), the shifted
// multiplicand (M), the multiplier (Q) and an iteration counter. Every add
// and every shift is issued to an external 32-bit ALU, and the ALU's
// registered result is collected one cycle later.
//
// Ports:
//   Clock      in   1   system clock, rising edge
//   Reset      in   1   synchronous, active-high reset
//   Start      in   1   request; sampled only while idle
//   MulA       in  16   multiplicand (unsigned), captured on accept
//   MulB       in  16   multiplier (unsigned), captured on accept
//   AluOut     in  32   ALU result, valid the cycle after an issue
//   AluA       out 32   ALU operand A
//   AluB       out 32   ALU operand B
//   AluFunSel  out  5   ALU function select
//   AluWF      out  1   ALU flag-write enable, always 0
//   Busy       out  1   operation in progress
//   Done       out  1   one-cycle pulse, Product valid while high
//   Product    out 32   result, held until the next result is written
//
// Every output except the constant AluWF comes straight from a flop. The
// values are computed from the next state, so each output lines up with the
// state it belongs to. The ALU operands are therefore on the bus during the
// ADD_I/SHL_I cycle, and the ALU result arrives during ADD_C/SHL_C.
// ---------------------------------------------------------------------------
module alu_multiply_sequencer #(
    parameter int ITER = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] MulA,
    input  logic [15:0] MulB,
    input  logic [31:0] AluOut,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product
);

    // ALU function codes used by the sequencer
    localparam logic [4:0] FUN_ADD  = 5'b10100;  // 32-bit A+B
    localparam logic [4:0] FUN_SHL  = 5'b11011;  // 32-bit logical shift left of A
    localparam logic [4:0] FUN_PASS = 5'b10000;  // pass A, idle code

    // Counter value of the final iteration
    localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIT   = 3'd1,
        ST_ADD_I = 3'd2,
        ST_ADD_C = 3'd3,
        ST_SHL_I = 3'd4,
        ST_SHL_C = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_p;         // partial product
    logic [31:0] r_m;         // shifted multiplicand
    logic [15:0] r_q;         // multiplier, consumed LSB first
    logic [3:0]  r_cnt;       // completed iterations

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [4:0]  r_alu_fun;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_product;

    logic        w_accept;
    logic [31:0] w_issue_a;
    logic [31:0] w_issue_b;
    logic [4:0]  w_issue_fun;
    logic        w_busy_next;
    logic        w_done_next;

    // Accept a request only while idle. Start in any other state is ignored.
    assign w_accept = (r_state == ST_IDLE) && Start;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = ST_BIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BIT: begin
                if (r_q[0]) begin
                    w_next_state = ST_ADD_I;
                end else begin
                    w_next_state = ST_SHL_I;
                end
            end
            ST_ADD_I: w_next_state = ST_ADD_C;
            ST_ADD_C: w_next_state = ST_SHL_I;
            ST_SHL_I: w_next_state = ST_SHL_C;
            ST_SHL_C: begin
                // All ITER iterations always run. There is no early exit on Q==0.
                if (r_cnt == LAST_CNT) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_BIT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ALU issue decode for the state being entered. P and M are stable on
    // every edge that enters ADD_I or SHL_I, so sampling them here is safe.
    always_comb begin
        w_issue_a   = 32'd0;
        w_issue_b   = 32'd0;
        w_issue_fun = FUN_PASS;
        case (w_next_state)
            ST_ADD_I: begin
                w_issue_a   = r_p;
                w_issue_b   = r_m;
                w_issue_fun = FUN_ADD;
            end
            ST_SHL_I: begin
                w_issue_a   = r_m;
                w_issue_b   = 32'd0;
                w_issue_fun = FUN_SHL;
            end
            default: begin
                w_issue_a   = 32'd0;
                w_issue_b   = 32'd0;
                w_issue_fun = FUN_PASS;
            end
        endcase
    end

    // Status decode for the state being entered
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_next_state)
            ST_BIT, ST_ADD_I, ST_ADD_C, ST_SHL_I, ST_SHL_C: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b0;
            end
            ST_DONE: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    // Multiply datapath: load on accept, collect ALU results in ADD_C/SHL_C
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_p   <= 32'd0;
            r_m   <= 32'd0;
            r_q   <= 16'd0;
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_p   <= 32'd0;
            r_m   <= {16'd0, MulA};
            r_q   <= MulB;
            r_cnt <= 4'd0;
        end else if (r_state == ST_ADD_C) begin
            // ALU carry-out is ignored. The final product always fits in 32 bits.
            r_p   <= AluOut;
        end else if (r_state == ST_SHL_C) begin
            r_m   <= AluOut;
            r_q   <= {1'b0, r_q[15:1]};
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_p   <= r_p;
            r_m   <= r_m;
            r_q   <= r_q;
            r_cnt <= r_cnt;
        end
    end

    // Registered ALU request and status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_fun <= FUN_PASS;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_alu_a   <= w_issue_a;
            r_alu_b   <= w_issue_b;
            r_alu_fun <= w_issue_fun;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // Result register. P is final after the last SHL_C, so it is captured
    // on the edge into DONE, in the same cycle that Done rises.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_product <= 32'd0;
        end else if (w_done_next) begin
            r_product <= r_p;
        end else begin
            r_product <= r_product;
        end
    end

    assign AluA      = r_alu_a;
    assign AluB      = r_alu_b;
    assign AluFunSel = r_alu_fun;
    assign AluWF     = 1'b0;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Product   = r_product;

endmodule
